// File: rtl/per_epoch_sequencer_if.sv
// Host/core-facing bundle of the per-epoch sequencer.
// master: the sequencer; slave: the host and core side.
interface per_epoch_sequencer_if #(
    parameter int ADDR_W  = 11,
    parameter int EPOCH_W = 8
);
    logic               start;
    logic               abort;
    logic               core_rst;
    logic [3:0]         core_control;
    logic [ADDR_W-1:0]  sample_addr;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               epoch_done;
    logic               done;

    modport master (
        input  start, abort,
        output core_rst, core_control, sample_addr, epoch,
        output busy, epoch_done, done
    );

    modport slave (
        output start, abort,
        input  core_rst, core_control, sample_addr, epoch,
        input  busy, epoch_done, done
    );
endinterface

// File: rtl/per_epoch_sequencer.sv
// Per-sample PRE/LOAD/RUN sequencing of the perceptron core
// over NUM_SAMPLES samples and NUM_EPOCHS epochs.
module per_epoch_sequencer #(
    parameter int         ADDR_W      = 11,
    parameter int         NUM_SAMPLES = 501,
    parameter int         NUM_EPOCHS  = 1,
    parameter int         EPOCH_W     = 8,
    parameter int         PRE_CYCLES  = 1,
    parameter int         LOAD_CYCLES = 5,
    parameter int         RUN_CYCLES  = 30,
    parameter logic [3:0] CTRL_RUN    = 4'b1111
) (
    input logic clk,
    input logic rst,
    per_epoch_sequencer_if.master bus
);
    localparam int CMAX0 = (PRE_CYCLES > LOAD_CYCLES) ? PRE_CYCLES : LOAD_CYCLES;
    localparam int CMAX  = (CMAX0 > RUN_CYCLES) ? CMAX0 : RUN_CYCLES;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNT_W-1:0]   PRE_RLD   = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOAD_RLD  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RUN_RLD   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] LAST_EP   = EPOCH_W'(NUM_EPOCHS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [EPOCH_W-1:0] ep_n;
    logic               ed_n;
    logic               dn_n;

    // Next state, phase counter and sample/epoch stepping.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = bus.sample_addr;
        ep_n    = bus.epoch;
        ed_n    = 1'b0;
        dn_n    = 1'b0;
        if (state == S_IDLE) begin
            // A start seen during the done cycle is dropped.
            if (bus.start && !bus.abort && !bus.done) begin
                state_n = S_PRE;
                cnt_n   = PRE_RLD;
                addr_n  = '0;
                ep_n    = '0;
            end
        end else if (bus.abort) begin
            state_n = S_IDLE;
        end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end else begin
            case (state)
                S_PRE: begin
                    state_n = S_LOAD;
                    cnt_n   = LOAD_RLD;
                end
                S_LOAD: begin
                    state_n = S_RUN;
                    cnt_n   = RUN_RLD;
                end
                S_RUN: begin
                    state_n = S_PRE;
                    cnt_n   = PRE_RLD;
                    if (bus.sample_addr != LAST_ADDR) begin
                        addr_n = bus.sample_addr + 1'b1;
                    end else if (bus.epoch != LAST_EP) begin
                        addr_n = '0;
                        ep_n   = bus.epoch + 1'b1;
                        ed_n   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        ed_n    = 1'b1;
                        dn_n    = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            bus.core_rst     <= 1'b0;
            bus.core_control <= '0;
            bus.sample_addr  <= '0;
            bus.epoch        <= '0;
            bus.busy         <= 1'b0;
            bus.epoch_done   <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            bus.core_rst     <= (state_n == S_LOAD);
            bus.core_control <= (state_n == S_RUN) ? CTRL_RUN : 4'b0000;
            bus.sample_addr  <= addr_n;
            bus.epoch        <= ep_n;
            bus.busy         <= (state_n != S_IDLE);
            bus.epoch_done   <= ed_n;
            bus.done         <= dn_n;
        end
    end
endmodule

// File: tb/tb_per_epoch_sequencer.sv
// Bench for per_epoch_sequencer: three configurations checked
// against a timing-formula model plus hand-computed points.
module tb_per_epoch_sequencer;
    localparam int PER = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    per_epoch_sequencer_if #(.ADDR_W(11), .EPOCH_W(8)) if0 ();
    per_epoch_sequencer_if #(.ADDR_W(11), .EPOCH_W(8)) if1 ();
    per_epoch_sequencer_if #(.ADDR_W(11), .EPOCH_W(8)) if2 ();

    per_epoch_sequencer dut0 (.clk(clk), .rst(rst), .bus(if0));
    per_epoch_sequencer #(.NUM_SAMPLES(3), .NUM_EPOCHS(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    per_epoch_sequencer #(.NUM_SAMPLES(2), .NUM_EPOCHS(1)) dut2 (
        .clk(clk), .rst(rst), .bus(if2));

    logic [26:0] act0, act1, act2;
    assign act0 = {if0.busy, if0.core_rst, if0.core_control, if0.epoch_done,
                   if0.done, if0.sample_addr, if0.epoch};
    assign act1 = {if1.busy, if1.core_rst, if1.core_control, if1.epoch_done,
                   if1.done, if1.sample_addr, if1.epoch};
    assign act2 = {if2.busy, if2.core_rst, if2.core_control, if2.epoch_done,
                   if2.done, if2.sample_addr, if2.epoch};

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int k = 0;

    int ns [3] = '{501, 3, 2};
    int ne [3] = '{1, 2, 1};
    bit run [3];
    int kk [3];
    bit e_busy [3];
    bit e_rst [3];
    bit e_ed [3];
    bit e_dn [3];
    logic [3:0] e_ctrl [3];
    int e_addr [3];
    int e_ep [3];

    function automatic logic [26:0] mk(bit b, bit r, logic [3:0] c,
                                       bit ed, bit dn, int a, int e);
        return {b, r, c, ed, dn, 11'(a), 8'(e)};
    endfunction

    function automatic logic [26:0] act(int i);
        case (i)
            0: return act0;
            1: return act1;
            default: return act2;
        endcase
    endfunction

    task automatic check(string name, logic [26:0] a, logic [26:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, e);
        end
    endtask

    // Expected outputs from elapsed cycles since the accepted start.
    task automatic model_step(int i, logic st, logic ab);
        int t;
        int s;
        int off;
        bit pdn;
        pdn = e_dn[i];
        off = 0;
        e_ed[i] = 0;
        e_dn[i] = 0;
        if (!rst) begin
            run[i] = 0;
            e_addr[i] = 0;
            e_ep[i] = 0;
        end else if (!run[i]) begin
            if (st === 1'b1 && ab !== 1'b1 && !pdn) begin
                run[i] = 1;
                kk[i] = cyc;
                e_addr[i] = 0;
                e_ep[i] = 0;
            end
        end else if (ab === 1'b1) begin
            run[i] = 0;
        end
        if (rst && run[i]) begin
            t = cyc - kk[i] + 1;
            if (t > ns[i] * ne[i] * PER) begin
                run[i] = 0;
                e_ed[i] = 1;
                e_dn[i] = 1;
            end else begin
                s = (t - 1) / PER;
                off = (t - 1) % PER;
                e_addr[i] = s % ns[i];
                e_ep[i] = s / ns[i];
                e_ed[i] = (off == 0 && s > 0 && s % ns[i] == 0);
            end
        end
        e_busy[i] = run[i];
        e_rst[i] = run[i] && off >= 1 && off <= 5;
        e_ctrl[i] = (run[i] && off >= 6) ? 4'hF : 4'h0;
    endtask

    function automatic logic [26:0] exp_vec(int i);
        return mk(e_busy[i], e_rst[i], e_ctrl[i], e_ed[i], e_dn[i],
                  e_addr[i], e_ep[i]);
    endfunction

    // Per-cycle model update and comparison, 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            model_step(0, if0.start, if0.abort);
            model_step(1, if1.start, if1.abort);
            model_step(2, if2.start, if2.abort);
            #1;
            check("model_dut0", act0, exp_vec(0));
            check("model_dut1", act1, exp_vec(1));
            check("model_dut2", act2, exp_vec(2));
            check("excl_dut0", {26'd0, if0.core_rst & (|if0.core_control)}, 27'd0);
            check("excl_dut1", {26'd0, if1.core_rst & (|if1.core_control)}, 27'd0);
            check("excl_dut2", {26'd0, if2.core_rst & (|if2.core_control)}, 27'd0);
        end
    end

    task automatic set_start(int i, logic v);
        case (i)
            0: if0.start = v;
            1: if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    task automatic set_abort(int i, logic v);
        case (i)
            0: if0.abort = v;
            1: if1.abort = v;
            default: if2.abort = v;
        endcase
    endtask

    task automatic go(int i, bit hold);
        @(negedge clk);
        set_start(i, 1'b1);
        @(posedge clk);
        #2;
        k = cyc;
        if (!hold) begin
            @(negedge clk);
            set_start(i, 1'b0);
        end
    endtask

    task automatic at(int n);
        int g;
        g = 0;
        while (cyc < k + n - 1 && g < 2000) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (cyc != k + n - 1) begin
            checks++;
            failures++;
            $display("FAIL wait_cycle got=%0d want=%0d", cyc, k + n - 1);
        end
    endtask

    task automatic abort_pulse(int i);
        @(negedge clk);
        set_abort(i, 1'b1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_start(i, 1'b1);
            set_abort(i, 1'b0);
        end
        repeat (3) @(posedge clk);
        #2;
        check("rst_dut0", act0, 27'd0);
        check("rst_dut1", act1, 27'd0);
        check("rst_dut2", act2, 27'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) set_start(i, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("idle_after_rst", act0 | act1 | act2, 27'd0);

        go(0, 1'b0);
        at(1);  check("d0_c1", act(0), mk(1, 0, 4'h0, 0, 0, 0, 0));
        at(2);  check("d0_c2", act(0), mk(1, 1, 4'h0, 0, 0, 0, 0));
        at(6);  check("d0_c6", act(0), mk(1, 1, 4'h0, 0, 0, 0, 0));
        at(7);  check("d0_c7", act(0), mk(1, 0, 4'hF, 0, 0, 0, 0));
        at(36); check("d0_c36", act(0), mk(1, 0, 4'hF, 0, 0, 0, 0));
        at(37); check("d0_c37", act(0), mk(1, 0, 4'h0, 0, 0, 1, 0));
        abort_pulse(0);
        check("d0_abort", act(0), mk(0, 0, 4'h0, 0, 0, 1, 0));
        @(negedge clk);
        set_abort(0, 1'b0);

        go(1, 1'b0);
        at(108); check("d1_c108", act(1), mk(1, 0, 4'hF, 0, 0, 2, 0));
        at(109); check("d1_c109", act(1), mk(1, 0, 4'h0, 1, 0, 0, 1));
        at(110); check("d1_c110", act(1), mk(1, 1, 4'h0, 0, 0, 0, 1));
        at(217); check("d1_c217", act(1), mk(0, 0, 4'h0, 1, 1, 2, 1));
        at(218); check("d1_c218", act(1), mk(0, 0, 4'h0, 0, 0, 2, 1));

        go(1, 1'b0);
        at(75); check("d1_load_s2", act(1), mk(1, 1, 4'h0, 0, 0, 2, 0));
        abort_pulse(1);
        check("d1_abort", act(1), mk(0, 0, 4'h0, 0, 0, 2, 0));
        @(negedge clk);
        set_abort(1, 1'b0);
        @(posedge clk);
        #2;
        check("d1_no_done", act(1), mk(0, 0, 4'h0, 0, 0, 2, 0));
        go(1, 1'b0);
        at(1);  check("d1_restart", act(1), mk(1, 0, 4'h0, 0, 0, 0, 0));
        at(40); check("d1_rs_c40", act(1), mk(1, 1, 4'h0, 0, 0, 1, 0));
        abort_pulse(1);
        @(negedge clk);
        set_abort(1, 1'b0);

        @(negedge clk);
        set_start(2, 1'b1);
        set_abort(2, 1'b1);
        @(posedge clk);
        #2;
        check("d2_start_abort", act(2), mk(0, 0, 4'h0, 0, 0, 0, 0));
        set_abort(2, 1'b0);
        go(2, 1'b1);
        at(1);  check("d2_c1", act(2), mk(1, 0, 4'h0, 0, 0, 0, 0));
        at(72); check("d2_c72", act(2), mk(1, 0, 4'hF, 0, 0, 1, 0));
        at(73); check("d2_c73", act(2), mk(0, 0, 4'h0, 1, 1, 1, 0));
        at(74); check("d2_c74", act(2), mk(0, 0, 4'h0, 0, 0, 1, 0));
        at(75); check("d2_c75", act(2), mk(1, 0, 4'h0, 0, 0, 0, 0));
        @(negedge clk);
        set_start(2, 1'b0);
        abort_pulse(2);
        @(negedge clk);
        set_abort(2, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
